subtrator_serial: RTL and testbench

- Bit-serial N-bit subtractor sequencer. Captures two operands and feeds one bit pair per clock, LSB first, into a single full-subtractor cell.
- Registers the cell's borrow back into its borrow input each cycle.
- Assembles the difference word, then presents result, final borrow and a done pulse to the downstream consumer.
- Sits directly upstream of the 1-bit full-subtractor cell and wraps it into a multi-bit, handshaked datapath.

---
 rtl/subtrator_serial_pkg.sv | 25 ++
 rtl/subtrator_serial_if.sv | 45 ++++
 rtl/subtrator_serial_cell.sv | 21 ++
 rtl/subtrator_serial.sv | 133 +++++++++++++
 tb/tb_subtrator_serial.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/subtrator_serial_pkg.sv
// -----------------------------------------------------------------------------
// subtrator_serial_pkg
// Shared definitions for the bit-serial subtractor.
//   - state_t      : FSM encoding (IDLE=0, SHIFT=1, DONE=2)
//   - DEFAULT_WIDTH: default operand/result width
//   - cnt_width()  : bit-counter width derived from the operand width
// Optional feature macro used by the files importing this package:
//   SUB_OVERFLOW_EN (adds the signed overflow flag).
// -----------------------------------------------------------------------------
package subtrator_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : subtrator_serial_pkg

// File: rtl/subtrator_serial_if.sv
// -----------------------------------------------------------------------------
// subtrator_serial_if
// Request/result bundle between a requester (master) and the serial
// subtractor (slave).
//   start      : request, capture a/b and begin            (master -> slave)
//   a, b       : minuend / subtrahend, WIDTH bits          (master -> slave)
//   busy       : high while shifting                       (slave -> master)
//   done       : one-cycle completion pulse                (slave -> master)
//   result     : a - b mod 2^WIDTH, held                   (slave -> master)
//   borrow_out : final borrow (a < b unsigned), held       (slave -> master)
//   overflow   : signed overflow, only with SUB_OVERFLOW_EN (slave -> master)
// -----------------------------------------------------------------------------
interface subtrator_serial_if
    import subtrator_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             borrow_out;
`ifdef SUB_OVERFLOW_EN
    logic             overflow;
`endif

    modport master (
        output start, a, b,
        input  busy, done, result, borrow_out
`ifdef SUB_OVERFLOW_EN
        , input overflow
`endif
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, borrow_out
`ifdef SUB_OVERFLOW_EN
        , output overflow
`endif
    );

endinterface : subtrator_serial_if

// File: rtl/subtrator_serial_cell.sv
// -----------------------------------------------------------------------------
// Subtrator1Bit
// One-bit full subtractor cell: computes a - b - bin.
//   a_i, b_i : operand bits
//   bin_i    : borrow in
//   d_o      : difference bit
//   bout_o   : borrow out
// -----------------------------------------------------------------------------
module Subtrator1Bit (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    // Borrow when b exceeds a, or when they are equal and a borrow comes in.
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule : Subtrator1Bit

// File: rtl/subtrator_serial.sv
// -----------------------------------------------------------------------------
// subtrator_serial
// Bit-serial WIDTH-bit subtractor. On an accepted start the operands are
// captured and fed LSB first, one bit pair per clock, through a single
// Subtrator1Bit cell whose borrow is registered back into its input.
// After WIDTH bits the assembled difference and final borrow are published
// and done pulses for one cycle.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : subtrator_serial_if.slave (start/a/b in; busy/done/result/
//           borrow_out[/overflow] out)
// Optional feature macro: SUB_OVERFLOW_EN adds the signed overflow flag.
// -----------------------------------------------------------------------------
module subtrator_serial
    import subtrator_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    subtrator_serial_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_sr_q;
    logic [WIDTH-1:0] result_q;
    logic             borrow_out_q;
`ifdef SUB_OVERFLOW_EN
    logic             a_msb_q;
    logic             b_msb_q;
    logic             overflow_q;
`endif

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] res_sr_d;

    Subtrator1Bit u_cell (
        .a_i    (a_sr_q[0]),
        .b_i    (b_sr_q[0]),
        .bin_i  (borrow_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts the first
    // (LSB) bit has travelled down to bit 0.
    assign res_sr_d = WIDTH'({cell_d, res_sr_q} >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_sr_q     <= '0;
            result_q     <= '0;
            borrow_out_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            overflow_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sr_q   <= bus.a;
                        b_sr_q   <= bus.b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
`ifdef SUB_OVERFLOW_EN
                        a_msb_q  <= bus.a[WIDTH-1];
                        b_msb_q  <= bus.b[WIDTH-1];
`endif
                        state_q  <= SHIFT;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    res_sr_q <= res_sr_d;
                    borrow_q <= cell_bout;
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        result_q     <= res_sr_d;
                        borrow_out_q <= cell_bout;
`ifdef SUB_OVERFLOW_EN
                        // cell_d is the result MSB on the last bit.
                        overflow_q   <= (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end else begin
                        busy_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.borrow_out = borrow_out_q;
`ifdef SUB_OVERFLOW_EN
    assign bus.overflow   = overflow_q;
`endif

endmodule : subtrator_serial

// File: tb/tb_subtrator_serial.sv
module tb_subtrator_serial;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         bor;
        logic         ovf;
    } exp_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   done_cnt;
    exp_t sb_q[$];

    subtrator_serial_if #(.WIDTH(W)) bus ();

    subtrator_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model of the subtraction.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.res = a - b;
        e.bor = (a < b);
        e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        return e;
    endfunction

    // Drive a one-cycle start and record the expected outcome.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        sb_q.push_back(model(a, b));
        tick();
        bus.start = 1'b0;
        $display("[TB] start a=%02h b=%02h", a, b);
    endtask

    // Bounded wait for done; checks the number of edges it took.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(a, b);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(tag, W);
        tick();
        check({tag, "_done_clears"}, 32'(bus.done), 32'd0);
    endtask

    // Scoreboard: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("result", 32'(bus.result), 32'(e.res));
                check("borrow_out", 32'(bus.borrow_out), 32'(e.bor));
`ifdef SUB_OVERFLOW_EN
                check("overflow", 32'(bus.overflow), 32'(e.ovf));
`endif
                $display("[TB] done result=%02h borrow=%0b (exp %02h/%0b)",
                         bus.result, bus.borrow_out, e.res, e.bor);
            end
        end
    end

    initial begin
        int base_cnt;
        tests     = 0;
        fails     = 0;
        done_cnt  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SUB_OVERFLOW_EN
        check("rst_overflow", 32'(bus.overflow), 32'd0);
`endif
        reset = 1'b0;
        tick();

        // Basic operation with busy tracked every cycle.
        start_op(8'h35, 8'h12);
        for (int i = 0; i < W; i++) begin
            check("t1_busy", 32'(bus.busy), 32'd1);
            check("t1_nodone", 32'(bus.done), 32'd0);
            if (i < W - 1) tick();
        end
        tick();
        check("t1_done", 32'(bus.done), 32'd1);
        check("t1_busy_low", 32'(bus.busy), 32'd0);
        tick();
        check("t1_done_clears", 32'(bus.done), 32'd0);
        check("t1_result_held", 32'(bus.result), 32'h23);

        // Start during SHIFT is ignored; old result visible until completion.
        base_cnt = done_cnt;
        start_op(8'h00, 8'h01);
        tick();
        tick();
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        tick();
        bus.start = 1'b0;
        check("ign_busy", 32'(bus.busy), 32'd1);
        check("ign_old_result", 32'(bus.result), 32'h23);
        wait_done("ign", W - 3);
        repeat (12) tick();
        check("ign_single_done", 32'(done_cnt - base_cnt), 32'd1);
        check("ign_idle", 32'(bus.busy), 32'd0);

        run_op("ff_ff", 8'hFF, 8'hFF);

        // Start held high: back-to-back acceptance from DONE.
        sb_q.push_back(model(8'h10, 8'h01));
        sb_q.push_back(model(8'h01, 8'h10));
        bus.a     = 8'h10;
        bus.b     = 8'h01;
        bus.start = 1'b1;
        tick();
        bus.a     = 8'h01;
        bus.b     = 8'h10;
        wait_done("held1", W);
        tick();
        bus.start = 1'b0;
        check("held_restart_busy", 32'(bus.busy), 32'd1);
        wait_done("held2", W);
        tick();

        // Asynchronous reset mid-operation.
        base_cnt = done_cnt;
        start_op(8'h35, 8'h12);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_result", 32'(bus.result), 32'd0);
        check("mid_rst_borrow", 32'(bus.borrow_out), 32'd0);
        sb_q.delete();
        tick();
        reset = 1'b0;
        repeat (12) tick();
        check("mid_rst_no_done", 32'(done_cnt - base_cnt), 32'd0);
        run_op("after_rst", 8'h07, 8'h03);

        // Signed overflow boundary cases.
        run_op("ovf_80_01", 8'h80, 8'h01);
        run_op("ovf_7f_ff", 8'h7F, 8'hFF);
        run_op("ovf_05_03", 8'h05, 8'h03);

        repeat (3) tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_subtrator_serial
